// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath input reorderer.
//   DEFAULT_WIDTH : default real/imag component width
//   MAX_LOG2N     : largest supported log2 frame length
//   bank_state_e  : per-bank ping-pong state
//   bitrev()      : reverse the low log2n bits of an address
package fft_pkg;

  localparam int unsigned DEFAULT_WIDTH = 18;
  localparam int unsigned MAX_LOG2N     = 10;
  localparam int unsigned IDX_W         = 4;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // Bits at or above log2n in the result are zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                  input int unsigned log2n);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_LOG2N; i++) begin
      if (i < log2n) begin
        r[IDX_W'(i)] = value[IDX_W'(log2n - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_bank.sv
// One N-entry complex sample bank: synchronous write, combinational read.
//   clk          : rising-edge clock
//   we           : write enable
//   waddr        : write address (natural order)
//   wre / wim    : write data, real / imaginary
//   raddr        : read address
//   rre / rim    : read data, real / imaginary
module bitrev_bank
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LOG2N = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [LOG2N-1:0]        waddr,
  input  logic signed [WIDTH-1:0] wre,
  input  logic signed [WIDTH-1:0] wim,
  input  logic [LOG2N-1:0]        raddr,
  output logic signed [WIDTH-1:0] rre,
  output logic signed [WIDTH-1:0] rim
);

  localparam int unsigned N = 1 << LOG2N;

  // Storage is deliberately not reset; stale contents are never read
  // because a bank is only drained after a complete fill.
  logic [2*WIDTH-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= {wre, wim};
    end
  end

  assign rre = mem[raddr][2*WIDTH-1:WIDTH];
  assign rim = mem[raddr][WIDTH-1:0];

endmodule

// File: rtl/bitrev_pingpong.sv
// Streaming natural-order to bit-reversed-order frame reorderer with two
// ping-pong banks, so one frame loads while the previous one drains.
//   clk, rst           : clock, asynchronous active-low reset
//   di_re/di_im/di_en  : input sample and valid
//   di_ready           : write bank can take a sample (from state only)
//   do_re/do_im/do_en  : registered output sample and valid
//   do_ready           : downstream accept
//   do_last            : marks the N-th sample of an output frame
module bitrev_pingpong
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LOG2N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  input  logic                    di_en,
  output logic                    di_ready,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic                    do_en,
  input  logic                    do_ready,
  output logic                    do_last
);

  localparam int unsigned N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

  bank_state_e st_q [2];
  bank_state_e st_d [2];
  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;

  logic do_en_d, do_last_d;
  logic signed [WIDTH-1:0] do_re_d, do_im_d;

  logic wr_fire, rd_fire, out_free;
  logic [LOG2N-1:0] rd_addr;
  logic signed [WIDTH-1:0] bank_re [2];
  logic signed [WIDTH-1:0] bank_im [2];

  assign di_ready = (st_q[wr_bank_q] == EMPTY) || (st_q[wr_bank_q] == FILLING);
  assign wr_fire  = di_en && di_ready;
  assign out_free = !do_en || do_ready;
  assign rd_fire  = out_free &&
                    ((st_q[rd_bank_q] == FULL) || (st_q[rd_bank_q] == DRAINING));
  assign rd_addr  = LOG2N'(bitrev(MAX_LOG2N'(rd_cnt_q), LOG2N));

  // Both banks share the read address; the top selects by rd_bank.
  for (genvar g = 0; g < 2; g++) begin : g_bank
    bitrev_bank #(
      .WIDTH (WIDTH),
      .LOG2N (LOG2N)
    ) u_bank (
      .clk   (clk),
      .we    (wr_fire && (wr_bank_q == 1'(g))),
      .waddr (wr_cnt_q),
      .wre   (di_re),
      .wim   (di_im),
      .raddr (rd_addr),
      .rre   (bank_re[g]),
      .rim   (bank_im[g])
    );
  end

  // State, counter and output register update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q[0]   <= EMPTY;
      st_q[1]   <= EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      do_en     <= 1'b0;
      do_last   <= 1'b0;
      do_re     <= '0;
      do_im     <= '0;
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      do_en     <= do_en_d;
      do_last   <= do_last_d;
      do_re     <= do_re_d;
      do_im     <= do_im_d;
    end
  end

  // Next-state: write and read never target the same bank in one cycle,
  // since a write needs EMPTY/FILLING and a read needs FULL/DRAINING.
  always_comb begin
    st_d[0]   = st_q[0];
    st_d[1]   = st_q[1];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    do_en_d   = do_en;
    do_last_d = do_last;
    do_re_d   = do_re;
    do_im_d   = do_im;

    if (wr_fire) begin
      if (wr_cnt_q == CNT_LAST) begin
        st_d[wr_bank_q] = FULL;
        wr_cnt_d        = '0;
        wr_bank_d       = !wr_bank_q;
      end else begin
        st_d[wr_bank_q] = FILLING;
        wr_cnt_d        = wr_cnt_q + LOG2N'(1);
      end
    end

    if (rd_fire) begin
      if (rd_cnt_q == CNT_LAST) begin
        st_d[rd_bank_q] = EMPTY;
        rd_cnt_d        = '0;
        rd_bank_d       = !rd_bank_q;
      end else begin
        st_d[rd_bank_q] = DRAINING;
        rd_cnt_d        = rd_cnt_q + LOG2N'(1);
      end
      do_en_d   = 1'b1;
      do_last_d = (rd_cnt_q == CNT_LAST);
      do_re_d   = bank_re[rd_bank_q];
      do_im_d   = bank_im[rd_bank_q];
    end else if (out_free) begin
      do_en_d   = 1'b0;
      do_last_d = 1'b0;
      do_re_d   = '0;
      do_im_d   = '0;
    end
  end

endmodule

// File: tb/tb_bitrev_pingpong.sv
// Directed bench for bitrev_pingpong (WIDTH=18, LOG2N=4).
module tb_bitrev_pingpong;

  localparam int W = 18;

  logic clk;
  logic rst;
  logic signed [W-1:0] di_re, di_im, do_re, do_im;
  logic di_en, di_ready, do_en, do_ready, do_last;

  bitrev_pingpong #(.WIDTH(W), .LOG2N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .di_re    (di_re),
    .di_im    (di_im),
    .di_en    (di_en),
    .di_ready (di_ready),
    .do_re    (do_re),
    .do_im    (do_im),
    .do_en    (do_en),
    .do_ready (do_ready),
    .do_last  (do_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int br [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  typedef struct {
    int re;
    int im;
    bit last;
    int cyc;
  } obs_t;

  obs_t q[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int push_waits = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer; do_ready is stable at the falling edge.
  always @(negedge clk) begin
    if (rst && do_en && do_ready) q.push_back('{int'(do_re), int'(do_im), do_last, cyc});
  end

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push(input int re, input int im);
    bit ok;
    ok = 1'b0;
    di_en = 1'b1;
    di_re = W'(re);
    di_im = W'(im);
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (di_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        push_waits++;
      end
    end
    di_en = 1'b0;
    if (!ok) check("push_accept", int'(ok), 1);
  endtask

  task automatic wait_q(input string tag, input int n);
    for (int t = 0; t < 2000 && q.size() < n; t++) @(posedge clk);
    #1;
    check(tag, q.size(), n);
  endtask

  task automatic apply_reset(input string tag);
    di_en = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check({tag, "_do_en"}, int'(do_en), 0);
    check({tag, "_do_last"}, int'(do_last), 0);
    check({tag, "_do_re"}, int'(do_re), 0);
    check({tag, "_do_im"}, int'(do_im), 0);
    check({tag, "_di_ready"}, int'(di_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
  endtask

  initial begin
    bit seen, hit, prev;
    rst = 1'b0;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;
    do_ready = 1'b1;
    #2;
    check("por_do_en", int'(do_en), 0);
    check("por_di_ready", int'(di_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single frame: latency, order, sign, do_last and gapless drain.
    for (int i = 0; i < 16; i++) push(i, -i);
    check("t1_lat_before", int'(do_en), 0);
    @(posedge clk);
    #1;
    check("t1_lat_after", int'(do_en), 1);
    check("t1_first_re", int'(do_re), 0);
    wait_q("t1_count", 16);
    for (int k = 0; k < 16 && k < q.size(); k++) begin
      check($sformatf("t1_re%0d", k), q[k].re, br[k]);
      check($sformatf("t1_im%0d", k), q[k].im, -br[k]);
      check($sformatf("t1_last%0d", k), int'(q[k].last), (k == 15) ? 1 : 0);
      check($sformatf("t1_cyc%0d", k), q[k].cyc - q[0].cyc, k);
    end
    q.delete();

    // Four back-to-back frames at full rate.
    push_waits = 0;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 16; i++) push(16 * f + i, -(16 * f + i));
    check("t2_ready_drop", push_waits, 0);
    wait_q("t2_count", 64);
    for (int n = 0; n < 64 && n < q.size(); n++) begin
      check($sformatf("t2_re%0d", n), q[n].re, 16 * (n / 16) + br[n % 16]);
      check($sformatf("t2_last%0d", n), int'(q[n].last), (n % 16 == 15) ? 1 : 0);
      check($sformatf("t2_cyc%0d", n), q[n].cyc - q[0].cyc, n);
    end
    q.delete();

    // Output stall of 5 cycles at output index 6 while input keeps flowing.
    fork
      begin
        for (int i = 0; i < 16; i++) push(i, 100 + i);
        for (int i = 0; i < 16; i++) push(16 + i, 116 + i);
        check("t3_ready_blocked", int'(di_ready), 0);
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(posedge clk);
          #1;
          if (do_en && int'(do_re) == 6) seen = 1'b1;
        end
        check("t3_seen6", int'(seen), 1);
        do_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk);
          #1;
          check($sformatf("t3_hold_re%0d", s), int'(do_re), 6);
          check($sformatf("t3_hold_im%0d", s), int'(do_im), 106);
          check($sformatf("t3_hold_en%0d", s), int'(do_en), 1);
        end
        do_ready = 1'b1;
      end
    join
    wait_q("t3_count", 32);
    for (int n = 0; n < 32 && n < q.size(); n++) begin
      check($sformatf("t3_re%0d", n), q[n].re, 16 * (n / 16) + br[n % 16]);
      check($sformatf("t3_im%0d", n), q[n].im, 100 + 16 * (n / 16) + br[n % 16]);
    end
    repeat (5) @(posedge clk);
    #1;
    check("t3_no_dup", q.size(), 32);

    // Both banks full under backpressure, then drain.
    apply_reset("t4_rst");
    do_ready = 1'b0;
    for (int i = 0; i < 32; i++) push(i, 50 + i);
    check("t4_ready_full", int'(di_ready), 0);
    di_en = 1'b1;
    di_re = W'(999);
    di_im = W'(999);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      check($sformatf("t4_ignored%0d", s), int'(di_ready), 0);
    end
    di_en = 1'b0;
    check("t4_no_xfer", q.size(), 0);
    check("t4_held_en", int'(do_en), 1);
    do_ready = 1'b1;
    hit = 1'b0;
    prev = 1'b1;
    for (int t = 0; t < 100 && !hit; t++) begin
      prev = di_ready;
      @(posedge clk);
      #1;
      if (do_en && do_last) hit = 1'b1;
    end
    check("t4_last_seen", int'(hit), 1);
    check("t4_ready_before", int'(prev), 0);
    check("t4_ready_after", int'(di_ready), 1);
    wait_q("t4_count", 32);
    for (int n = 0; n < 32 && n < q.size(); n++) begin
      check($sformatf("t4_re%0d", n), q[n].re, 16 * (n / 16) + br[n % 16]);
    end

    // Async reset mid-fill and mid-drain, then a clean frame.
    for (int i = 0; i < 7; i++) push(500 + i, 500 + i);
    apply_reset("t5_fill");
    do_ready = 1'b0;
    for (int i = 0; i < 32; i++) push(300 + i, 300 + i);
    check("t5_pre_ready", int'(di_ready), 0);
    check("t5_pre_re", int'(do_re), 300);
    apply_reset("t5_drain");
    do_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(40 + i, -(40 + i));
    wait_q("t5_count", 16);
    for (int k = 0; k < 16 && k < q.size(); k++) begin
      check($sformatf("t5_re%0d", k), q[k].re, 40 + br[k]);
      check($sformatf("t5_last%0d", k), int'(q[k].last), (k == 15) ? 1 : 0);
    end
    q.delete();

    // Signed extremes pass bit-exact.
    for (int i = 0; i < 16; i++)
      push((i % 2 == 1) ? 131071 : -131072, (i % 2 == 1) ? -131072 : 131071);
    wait_q("t6_count", 16);
    for (int k = 0; k < 16 && k < q.size(); k++) begin
      check($sformatf("t6_re%0d", k), q[k].re, (br[k] % 2 == 1) ? 131071 : -131072);
      check($sformatf("t6_im%0d", k), q[k].im, (br[k] % 2 == 1) ? -131072 : 131071);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
